mvm3_result_packer: RTL
=======================

Name: mvm3_result_packer

Overview:
Downstream stage of the 3x3 matrix-vector multiply core. Consumes the core's serial stream of signed 16-bit dot-product results, groups every N consecutive results into one output vector, and buffers up to DEPTH complete vectors. Each vector is presented as a single wide word on a valid/ready handshake to the next consumer (host interface / next layer).

Parameters:
N, 3, elements per output vector (matches matrix row count)
W, 16, element width in bits (signed, two's complement)
DEPTH, 4, vector slots in the output FIFO (power of 2, >= 2)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
s_valid  input  1  upstream result valid (driven by MVM core m_valid)
s_ready  output  1  packer can accept data_in this cycle (drives MVM core m_ready)
data_in  input  W  signed result element from MVM core
m_valid  output  1  a complete vector is available on data_out
m_ready  input  1  downstream accepts data_out this cycle
data_out  output  N*W  packed vector; element k at bits [k*W +: W]
vec_count  output  $clog2(DEPTH+1)  number of complete vectors held in FIFO

Behaviour:
- Accept = s_valid && s_ready. Pop = m_valid && m_ready.
- Assembly: elem_idx counter 0..N-1. On accept, data_in is written to assembly lane elem_idx and elem_idx increments. When elem_idx == N-1, it wraps to 0.
- Push: on accept with elem_idx == N-1, lanes 0..N-2 plus the current data_in are written as one vector into FIFO[wr_ptr] in the same edge. wr_ptr increments modulo DEPTH.
- s_ready = (elem_idx != N-1) || (count < DEPTH). Lanes 0..N-2 are always accepted. The final lane stalls only while the FIFO is full. s_ready has no combinational path from m_ready.
- m_valid = (count != 0). data_out = FIFO[rd_ptr], held stable while m_valid && !m_ready. Pop increments rd_ptr modulo DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop. vec_count = count.
- Full with final lane pending: s_ready = 0. The pop in that cycle frees a slot, and s_ready rises on the next cycle.
- Empty: m_valid = 0, and a pop cannot occur.
- Latency: final element accepted at edge t into an empty FIFO -> m_valid = 1 after edge t (visible in cycle t+1).
- Throughput: one element per cycle in, one vector per cycle out. No bubbles unless full.
- Pointers wrap silently. DEPTH is a power of 2 and count disambiguates full from empty.
- Reset (asynchronous assert, synchronous deassert handled externally):
  - elem_idx = 0, wr_ptr = rd_ptr = 0, count = 0.
  - Assembly lanes and FIFO storage are cleared to 0.
  - Outputs: m_valid = 0, s_ready = 1, data_out = 0, vec_count = 0.
- Reset mid-vector discards the partial vector. The next accepted element is lane 0.

Optional Feature:
- Macro MVM3_RELU_EN.
- Defined: each element is clamped at the push point. If bit W-1 is set, 0 is stored, so stored elements are never negative.
- Not defined: elements are stored verbatim.
- Clamping adds no latency and does not alter the handshake.

Test Plan:
- Reset then stream 3, -2, 7 with s_valid held and m_ready = 1 -> one cycle later m_valid = 1, data_out = {16'sd7, -16'sd2, 16'sd3}, vec_count = 1. Next cycle vec_count = 0.
- m_ready = 0; stream 4 vectors (12 elements) then elements 13-15 -> vec_count = 4. s_ready = 1 for elements 13-14 and 0 for element 15. After one pop, element 15 is accepted the next cycle.
- Full FIFO, simultaneous pop and final-lane accept attempt -> no push that cycle, count 4 -> 3. Push occurs the next cycle, count returns to 4. FIFO order is preserved: vectors pop in arrival order, including across pointer wrap (10 vectors through DEPTH = 4).
- m_valid high, m_ready toggled 0/1 randomly -> data_out stable while stalled, and no vector is lost or duplicated.
- Accept 2 elements, assert reset low for 1 cycle, then stream 9, 8, 7 -> output vector = {7, 8, 9}. The partial vector is dropped, and all outputs are 0/1 reset values during reset.
- With MVM3_RELU_EN: stream -5, 6, -32768 -> data_out = {0, 6, 0}. Without the macro -> {-32768, 6, -5}.

Source files
------------

// File: rtl/mvm3_result_packer.sv
// Groups N serial signed results from the MVM core into one packed vector and buffers
// up to DEPTH vectors on a valid/ready output. Optional macro MVM3_RELU_EN clamps negative elements to 0.
module mvm3_result_packer #(
   parameter int N     = 3,
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic signed [W-1:0]          data_in,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [N*W-1:0]               data_out,
   output logic [$clog2(DEPTH+1)-1:0]   vec_count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [IW-1:0]          r_elem_idx;
   logic signed [W-1:0]    r_lane [N-1];
   logic [N*W-1:0]         r_fifo [DEPTH];
   logic [PW-1:0]          r_wr_ptr;
   logic [PW-1:0]          r_rd_ptr;
   logic [CW-1:0]          r_count;

   logic                   w_last;
   logic                   w_accept;
   logic                   w_push;
   logic                   w_pop;
   logic [N*W-1:0]         w_vec;

   function automatic logic signed [W-1:0] clamp_elem(input logic signed [W-1:0] x);
`ifdef MVM3_RELU_EN
      return x[W-1] ? '0 : x;
`else
      return x;
`endif
   endfunction

   // s_ready depends only on registered state, never on m_ready
   assign w_last    = (r_elem_idx == IW'(N - 1));
   assign s_ready   = !w_last || (r_count < CW'(DEPTH));
   assign w_accept  = s_valid && s_ready;
   assign w_push    = w_accept && w_last;
   assign m_valid   = (r_count != '0);
   assign w_pop     = m_valid && m_ready;
   assign data_out  = r_fifo[r_rd_ptr];
   assign vec_count = r_count;

   always_comb begin
      w_vec = '0;
      for (int k = 0; k < N - 1; k++) begin
         w_vec[k*W +: W] = clamp_elem(r_lane[k]);
      end
      w_vec[(N-1)*W +: W] = clamp_elem(data_in);
   end

   // Assembly lanes and element index
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_elem_idx <= '0;
         for (int k = 0; k < N - 1; k++) begin
            r_lane[k] <= '0;
         end
      end else if (w_accept) begin
         if (w_last) begin
            r_elem_idx <= '0;
         end else begin
            r_elem_idx <= r_elem_idx + IW'(1);
            for (int k = 0; k < N - 1; k++) begin
               if (r_elem_idx == IW'(k)) begin
                  r_lane[k] <= data_in;
               end
            end
         end
      end
   end

   // Vector FIFO storage and pointers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int d = 0; d < DEPTH; d++) begin
            r_fifo[d] <= '0;
         end
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr] <= w_vec;
            r_wr_ptr         <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
      end
   end

   // Occupancy: simultaneous push and pop leaves it unchanged
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
